// File: rtl/rtc_pkg.sv
// Shared constants and types for the RTC counter/match stage.
package rtc_pkg;

  localparam int unsigned CNT_WIDTH = 32;
  localparam int unsigned DIV_WIDTH = 16;
  localparam logic [DIV_WIDTH-1:0] DIV_RESET = 16'd32767;

  // Prescaler run state.
  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRun  = 1'b1
  } rtc_state_e;

endpackage

// File: rtl/rtc_prescaler.sv
// Divides PCLK down to a one-cycle seconds tick. Owns the run/idle FSM,
// the programmable divisor and the prescaler counter.
module rtc_prescaler
  import rtc_pkg::*;
#(
  parameter int unsigned             DivWidth = DIV_WIDTH,
  parameter logic [DivWidth-1:0]     DivReset = DIV_RESET
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic                div_en_i,
  input  logic [DivWidth-1:0] div_data_i,
  output logic                tick_o
);

  rtc_state_e          state_q, state_d;
  logic [DivWidth-1:0] presc_q, presc_d;
  logic [DivWidth-1:0] div_q, div_d;
  logic                tick_q, tick_d;

  // Next-state: FSM transitions, prescaler count/wrap and divisor writes.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    div_d   = div_q;
    tick_d  = 1'b0;

    case (state_q)
      StIdle: begin
        presc_d = '0;
        if (start_i) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (!start_i) begin
          state_d = StIdle;
          presc_d = '0;
        end else if (presc_q == div_q) begin
          presc_d = '0;
          tick_d  = 1'b1;
        end else begin
          presc_d = presc_q + DivWidth'(1);
        end
      end
      default: begin
        state_d = StIdle;
        presc_d = '0;
      end
    endcase

    // A divisor write restarts the period so the first tick is a full
    // divisor+1 cycles away.
    if (div_en_i) begin
      div_d   = div_data_i;
      presc_d = '0;
      tick_d  = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      presc_q <= '0;
      div_q   <= DivReset;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      div_q   <= div_d;
      tick_q  <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/rtc_count_match.sv
// RTC data counter, match register, registered comparator and interrupt
// status flops. The seconds tick comes from rtc_prescaler.
module rtc_count_match
  import rtc_pkg::*;
#(
  parameter int unsigned           CntWidth = CNT_WIDTH,
  parameter int unsigned           DivWidth = DIV_WIDTH,
  parameter logic [DivWidth-1:0]   DivReset = DIV_RESET
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic                RtcStart,
  input  logic                LoadEn,
  input  logic [CntWidth-1:0] LoadData,
  input  logic                MatchEn,
  input  logic [CntWidth-1:0] MatchData,
  input  logic                DivEn,
  input  logic [DivWidth-1:0] DivData,
  input  logic                IntMask,
  input  logic                IntClear,
  output logic [CntWidth-1:0] RtcCount,
  output logic [CntWidth-1:0] RtcMatch,
  output logic                RawIntSync,
  output logic                RTCINTR,
  output logic                Tick
);

  logic                tick;
  logic [CntWidth-1:0] count_q, count_d;
  logic [CntWidth-1:0] match_q, match_d;
  logic                chg_q, chg_d;
  logic                raw_q, raw_d;
  logic                intr_q, intr_d;

  rtc_prescaler #(
    .DivWidth (DivWidth),
    .DivReset (DivReset)
  ) u_prescaler (
    .clk_i      (PCLK),
    .rst_ni     (PRESETn),
    .start_i    (RtcStart),
    .div_en_i   (DivEn),
    .div_data_i (DivData),
    .tick_o     (tick)
  );

  // Counter: load beats increment; chg_d records that the count took a new value.
  always_comb begin
    count_d = count_q;
    chg_d   = 1'b0;
    if (LoadEn) begin
      count_d = LoadData;
      chg_d   = 1'b1;
    end else if (tick) begin
      count_d = count_q + CntWidth'(1);
      chg_d   = 1'b1;
    end
  end

  // Match register, compare and interrupt status. Compare is qualified by
  // chg_q so a match write alone never raises the interrupt; set beats clear.
  always_comb begin
    match_d = MatchEn ? MatchData : match_q;
    raw_d   = (chg_q && (count_q == match_q)) || (raw_q && !IntClear);
    intr_d  = raw_q && IntMask;
  end

  // State registers.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      count_q <= '0;
      match_q <= '0;
      chg_q   <= 1'b0;
      raw_q   <= 1'b0;
      intr_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      match_q <= match_d;
      chg_q   <= chg_d;
      raw_q   <= raw_d;
      intr_q  <= intr_d;
    end
  end

  assign RtcCount   = count_q;
  assign RtcMatch   = match_q;
  assign RawIntSync = raw_q;
  assign RTCINTR    = intr_q;
  assign Tick       = tick;

endmodule

// File: tb/tb_rtc_count_match.sv
// Self-checking bench for rtc_count_match: directed scenarios followed by a
// random phase, every cycle compared against a behavioural model.
module tb_rtc_count_match;

  logic        PCLK;
  logic        PRESETn;
  logic        RtcStart;
  logic        LoadEn;
  logic [31:0] LoadData;
  logic        MatchEn;
  logic [31:0] MatchData;
  logic        DivEn;
  logic [15:0] DivData;
  logic        IntMask;
  logic        IntClear;
  logic [31:0] RtcCount;
  logic [31:0] RtcMatch;
  logic        RawIntSync;
  logic        RTCINTR;
  logic        Tick;

  int checks;
  int failures;

  // Reference model state.
  bit          m_run;
  logic [15:0] m_phase;
  logic [15:0] m_div;
  bit          m_tick;
  logic [31:0] m_count;
  logic [31:0] m_match;
  bit          m_new_value;
  bit          m_raw;
  bit          m_intr;

  rtc_count_match dut (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .RtcStart   (RtcStart),
    .LoadEn     (LoadEn),
    .LoadData   (LoadData),
    .MatchEn    (MatchEn),
    .MatchData  (MatchData),
    .DivEn      (DivEn),
    .DivData    (DivData),
    .IntMask    (IntMask),
    .IntClear   (IntClear),
    .RtcCount   (RtcCount),
    .RtcMatch   (RtcMatch),
    .RawIntSync (RawIntSync),
    .RTCINTR    (RTCINTR),
    .Tick       (Tick)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run       = 1'b0;
    m_phase     = '0;
    m_div       = 16'd32767;
    m_tick      = 1'b0;
    m_count     = '0;
    m_match     = '0;
    m_new_value = 1'b0;
    m_raw       = 1'b0;
    m_intr      = 1'b0;
  endtask

  // One PCLK of spec behaviour, using the inputs present before the edge.
  task automatic model_edge();
    bit          n_run, n_tick, n_new, n_raw, n_intr;
    logic [15:0] n_phase, n_div;
    logic [31:0] n_count, n_match;
    n_run   = RtcStart;
    n_div   = m_div;
    n_phase = '0;
    n_tick  = 1'b0;
    if (DivEn) n_div = DivData;
    else if (m_run && RtcStart) begin
      // Period is divisor+1 running cycles; tick when the last one ends.
      if (m_phase == m_div) n_tick = 1'b1;
      else n_phase = m_phase + 16'd1;
    end
    n_new   = LoadEn || m_tick;
    n_count = LoadEn ? LoadData : (m_tick ? m_count + 32'd1 : m_count);
    n_match = MatchEn ? MatchData : m_match;
    n_raw   = (m_new_value && (m_count == m_match)) || (m_raw && !IntClear);
    n_intr  = m_raw && IntMask;
    m_run = n_run; m_phase = n_phase; m_div = n_div; m_tick = n_tick;
    m_count = n_count; m_match = n_match; m_new_value = n_new;
    m_raw = n_raw; m_intr = n_intr;
  endtask

  task automatic check_all();
    chk("count", RtcCount, m_count);
    chk("match", RtcMatch, m_match);
    chk("raw",   32'(RawIntSync), 32'(m_raw));
    chk("intr",  32'(RTCINTR), 32'(m_intr));
    chk("tick",  32'(Tick), 32'(m_tick));
  endtask

  task automatic step();
    @(posedge PCLK);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_strobes();
    LoadEn = 1'b0; MatchEn = 1'b0; DivEn = 1'b0; IntClear = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    PRESETn = 1'b0; RtcStart = 1'b0; LoadEn = 1'b0; LoadData = '0;
    MatchEn = 1'b0; MatchData = '0; DivEn = 1'b0; DivData = '0;
    IntMask = 1'b0; IntClear = 1'b0;
    model_reset();
    #3;
    check_all();
    chk("reset_count", RtcCount, 32'd0);
    #4 PRESETn = 1'b1;
    step();

    // Divisor 3: tick every 4 cycles, count increments.
    DivEn = 1'b1; DivData = 16'd3; step(); clear_strobes();
    RtcStart = 1'b1; steps(18);
    // Wrap from all-ones.
    LoadEn = 1'b1; LoadData = 32'hFFFF_FFFF; step(); clear_strobes();
    chk("load_ffff", RtcCount, 32'hFFFF_FFFF);
    steps(5);
    chk("wrap_zero", RtcCount, 32'd0);

    // Load on a tick cycle: load wins over increment.
    DivEn = 1'b1; DivData = 16'd0; step(); clear_strobes();
    steps(3);
    LoadEn = 1'b1; LoadData = 32'h100; step(); clear_strobes();
    chk("load_vs_tick", RtcCount, 32'h100);

    // Match on increment.
    RtcStart = 1'b0; IntMask = 1'b1; step();
    LoadEn = 1'b1; LoadData = 32'd5; MatchEn = 1'b1; MatchData = 32'd7; step();
    clear_strobes();
    RtcStart = 1'b1; steps(8);
    chk("raw_held", 32'(RawIntSync), 32'd1);

    // Clear, then clear colliding with a fresh match.
    RtcStart = 1'b0; step();
    IntClear = 1'b1; step(); clear_strobes(); step();
    chk("raw_cleared", 32'(RawIntSync), 32'd0);
    LoadEn = 1'b1; LoadData = 32'd7; step(); clear_strobes();
    steps(2);
    LoadEn = 1'b1; LoadData = 32'd7; step(); clear_strobes();
    IntClear = 1'b1; step(); clear_strobes();
    chk("set_beats_clear", 32'(RawIntSync), 32'd1);
    steps(2);

    // Match by load; match write equal to count does not set.
    IntClear = 1'b1; MatchEn = 1'b1; MatchData = 32'h20; step(); clear_strobes();
    LoadEn = 1'b1; LoadData = 32'h20; step(); clear_strobes(); steps(2);
    chk("match_by_load", 32'(RawIntSync), 32'd1);
    LoadEn = 1'b1; LoadData = 32'h30; IntClear = 1'b1; step(); clear_strobes();
    steps(2);
    MatchEn = 1'b1; MatchData = 32'h30; step(); clear_strobes(); steps(3);
    chk("match_write_no_set", 32'(RawIntSync), 32'd0);

    // Stop mid-period and restart.
    DivEn = 1'b1; DivData = 16'd5; step(); clear_strobes();
    RtcStart = 1'b1; steps(9);
    RtcStart = 1'b0; steps(8);
    RtcStart = 1'b1; steps(14);

    // Asynchronous reset mid-run.
    PRESETn = 1'b0;
    #1;
    model_reset();
    check_all();
    #1 PRESETn = 1'b1;
    RtcStart = 1'b1; steps(10);

    // Random phase.
    for (int i = 0; i < 800; i++) begin
      RtcStart  = ($urandom_range(9, 0) != 0);
      LoadEn    = ($urandom_range(7, 0) == 0);
      LoadData  = 32'($urandom_range(15, 0));
      MatchEn   = ($urandom_range(11, 0) == 0);
      MatchData = 32'($urandom_range(15, 0));
      DivEn     = ($urandom_range(15, 0) == 0);
      DivData   = 16'($urandom_range(3, 0));
      IntMask   = ($urandom_range(3, 0) != 0);
      IntClear  = ($urandom_range(5, 0) == 0);
      if (i == 400) LoadData = 32'hFFFF_FFFE;
      step();
    end
    clear_strobes();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rtc_count_match.md
Name: rtc_count_match

Overview:
- PCLK-domain counter/match stage that sits directly upstream of the RTC interrupt-clear control logic.
- Prescales PCLK to a seconds tick, maintains the 32-bit RTC data counter, and compares it against the match register.
- Holds the raw interrupt status and presents it as RawIntSync; the gated IntClear pulse from the control logic clears it.
- Also produces the masked interrupt RTCINTR.

Parameters:
- CNT_WIDTH, 32, width of data counter, load and match values
- DIV_WIDTH, 16, width of prescaler divisor register/counter
- DIV_RESET, 16'd32767, divisor reset value (tick every DIV_RESET+1 PCLK cycles)

Ports:
- PCLK  input  1  APB clock; sole clock
- PRESETn  input  1  APB reset, asynchronous, active-low
- RtcStart  input  1  level; 1 = prescaler and counter run
- LoadEn  input  1  one-cycle write strobe for data register
- LoadData  input  CNT_WIDTH  value to load into counter
- MatchEn  input  1  one-cycle write strobe for match register
- MatchData  input  CNT_WIDTH  new match value
- DivEn  input  1  one-cycle write strobe for prescaler divisor
- DivData  input  DIV_WIDTH  new divisor
- IntMask  input  1  level; 1 = interrupt enabled onto RTCINTR
- IntClear  input  1  gated clear from control stage
- RtcCount  output  CNT_WIDTH  current counter value
- RtcMatch  output  CNT_WIDTH  current match register
- RawIntSync  output  1  raw interrupt status
- RTCINTR  output  1  RawIntSync AND IntMask, registered
- Tick  output  1  one-cycle seconds tick (debug/observe)

Behaviour:
- Clock and reset: one clock, PCLK. Asynchronous active-low reset, PRESETn.
- Reset values: RtcCount=0, RtcMatch=0, divisor=DIV_RESET, prescaler=0, Tick=0, RawIntSync=0, RTCINTR=0, FSM=IDLE.
- FSM states:
  - IDLE: RtcStart=0; prescaler held at 0; Tick=0.
  - RUN: prescaler increments each PCLK.
  - IDLE->RUN when RtcStart=1.
  - RUN->IDLE when RtcStart=0; prescaler cleared on exit.
- Prescaler:
  - In RUN, when prescaler==divisor: prescaler<=0 and Tick<=1 for exactly one cycle; otherwise prescaler+1.
  - divisor=0 gives a Tick every cycle.
  - A DivEn write updates the divisor and clears the prescaler in the same cycle, so the first tick comes divisor+1 cycles later.
- Counter:
  - On Tick, RtcCount<=RtcCount+1, modulo 2^CNT_WIDTH (0xFFFFFFFF wraps to 0, no flag).
  - LoadEn has priority over a simultaneous Tick increment: RtcCount<=LoadData; the tick is consumed; prescaler is unaffected.
  - Load is allowed in IDLE.
- Match register: updated on MatchEn; new value visible on RtcMatch the next cycle.
- Match detect:
  - Registered: RawIntSync set one cycle after RtcCount takes a value equal to RtcMatch via increment or via load.
  - Writing a match value equal to the current count does NOT set the interrupt; only a count change does.
- Raw status:
  - Once set, RawIntSync stays 1 until IntClear=1; then clears the next cycle.
  - Simultaneous set and IntClear: set wins, RawIntSync stays 1.
- RTCINTR:
  - Registered RawIntSync & IntMask, so one cycle behind RawIntSync.
  - Mask changes take effect the next cycle.
- Reset mid-operation: all state returns to reset values immediately (async); no tick or interrupt is produced on reset release until the full divisor period has elapsed in RUN.
- No combinational path from any input to any output.

Decomposition:
- Shared package rtc_pkg:
  - CNT_WIDTH and DIV_WIDTH constants
  - DIV_RESET constant
  - FSM state enum (IDLE, RUN)
- One natural sub-module, rtc_prescaler: owns the FSM, divisor register and prescaler counter; outputs Tick.
- The top level holds the counter, match register, comparator and interrupt flops.

Test Plan:
- Divisor and wrap: reset, DivData=3 via DivEn, RtcStart=1 -> Tick every 4 PCLKs. RtcCount 0,1,2,... Load 0xFFFFFFFF -> next tick gives 0.
- Match on increment: Load 5, Match 7, divisor 0, run. At RtcCount=7, RawIntSync=1 on the next cycle; with IntMask=1, RTCINTR=1 one cycle later. It stays set while the count moves to 8, 9.
- Clear and collision: with RawIntSync=1, pulse IntClear -> 0 next cycle. Repeat with IntClear coincident with a new match -> RawIntSync stays 1.
- Load vs tick: LoadEn=1, LoadData=0x100 on a Tick cycle -> RtcCount=0x100 (not 0x101).
- Match by load, and match write with no count change:
  - Match=0x20; loading 0x20 sets RawIntSync.
  - With count=0x30, writing Match=0x30 leaves RawIntSync at 0.
- Stop and reset: RtcStart=0 mid-period -> count frozen, no Tick. Restart -> first tick after divisor+1 cycles. Assert PRESETn low mid-run -> all outputs 0 immediately, divisor=DIV_RESET.
